rsa_job_scheduler: RTL and testbench

- Sequences one shared RSA `control` datapath (key inverter plus modular exponentiator) on behalf of two requesters, A and B.
- Arbitrates between A and B with round-robin priority.
- For each job: latches operands, pulses `reset_inverter`, waits for `inverter_finish`, pulses `reset_mod_exp`, waits for `mod_exp_finish`, then returns `msg_out` to the winning requester.
- Replaces the hand-written reset/wait sequencing currently done in benches and top-level glue.

---
 rtl/rsa_job_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_rsa_job_scheduler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_job_scheduler.sv
// Round-robin job sequencer that shares one RSA control datapath between requesters A and B.
// Define RSA_KEY_CACHE_EN to skip the key inverter when p/q match the last successful job.
module rsa_job_scheduler #(
    parameter int WIDTH          = 128,
    parameter int RST_CYCLES     = 1,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_a,
    input  logic [WIDTH-1:0]     p_a,
    input  logic [WIDTH-1:0]     q_a,
    input  logic                 ed_a,
    input  logic [2*WIDTH-1:0]   msg_a,
    output logic                 gnt_a,
    output logic                 done_a,
    input  logic                 req_b,
    input  logic [WIDTH-1:0]     p_b,
    input  logic [WIDTH-1:0]     q_b,
    input  logic                 ed_b,
    input  logic [2*WIDTH-1:0]   msg_b,
    output logic                 gnt_b,
    output logic                 done_b,
    output logic [2*WIDTH-1:0]   result,
    output logic                 err,
    output logic                 busy,
    output logic [WIDTH-1:0]     ctl_p,
    output logic [WIDTH-1:0]     ctl_q,
    output logic                 ctl_encrypt_decrypt,
    output logic [2*WIDTH-1:0]   ctl_msg_in,
    output logic                 ctl_reset_inverter,
    output logic                 ctl_reset_mod_exp,
    input  logic                 ctl_inverter_finish,
    input  logic                 ctl_mod_exp_finish,
    input  logic [2*WIDTH-1:0]   ctl_msg_out
);
    typedef enum logic [2:0] {
        IDLE, LOAD, INV_RST, INV_WAIT, EXP_RST, EXP_WAIT, DONE
    } state_t;

    localparam logic [3:0]  RST_LAST = 4'(RST_CYCLES - 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [3:0]  rst_cnt;
    logic [15:0] wait_cnt;
    logic        last_b;
    logic        owner_b;
    logic        pick_a;
    logic        fin_ok;
    logic        timed_out;
    logic        cache_hit;

    assign pick_a = req_a && (!req_b || last_b);

    // wait_cnt == 0 is the first cycle after the reset pulse; a finish there is left over from the previous job
    assign fin_ok = (wait_cnt != 16'd0) &&
                    ((state == INV_WAIT && ctl_inverter_finish) ||
                     (state == EXP_WAIT && ctl_mod_exp_finish));

    assign timed_out = (state == INV_WAIT || state == EXP_WAIT) && !fin_ok &&
                       (wait_cnt == TO_LAST);

`ifdef RSA_KEY_CACHE_EN
    logic [WIDTH-1:0] cached_p;
    logic [WIDTH-1:0] cached_q;
    logic             cache_valid;

    assign cache_hit = cache_valid && (ctl_p == cached_p) && (ctl_q == cached_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cached_p    <= '0;
            cached_q    <= '0;
            cache_valid <= 1'b0;
        end else if (state == EXP_WAIT && fin_ok) begin
            cached_p    <= ctl_p;
            cached_q    <= ctl_q;
            cache_valid <= 1'b1;
        end else if (timed_out) begin
            cache_valid <= 1'b0;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= IDLE;
            rst_cnt             <= '0;
            wait_cnt            <= '0;
            last_b              <= 1'b1;
            owner_b             <= 1'b0;
            gnt_a               <= 1'b0;
            gnt_b               <= 1'b0;
            done_a              <= 1'b0;
            done_b              <= 1'b0;
            result              <= '0;
            err                 <= 1'b0;
            busy                <= 1'b0;
            ctl_p               <= '0;
            ctl_q               <= '0;
            ctl_encrypt_decrypt <= 1'b0;
            ctl_msg_in          <= '0;
            ctl_reset_inverter  <= 1'b0;
            ctl_reset_mod_exp   <= 1'b0;
        end else begin
            gnt_a  <= 1'b0;
            gnt_b  <= 1'b0;
            done_a <= 1'b0;
            done_b <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_a || req_b) begin
                        state               <= LOAD;
                        busy                <= 1'b1;
                        owner_b             <= !pick_a;
                        last_b              <= !pick_a;
                        gnt_a               <= pick_a;
                        gnt_b               <= !pick_a;
                        ctl_p               <= pick_a ? p_a : p_b;
                        ctl_q               <= pick_a ? q_a : q_b;
                        ctl_encrypt_decrypt <= pick_a ? ed_a : ed_b;
                        ctl_msg_in          <= pick_a ? msg_a : msg_b;
                    end
                end
                LOAD: begin
                    rst_cnt <= '0;
                    if (cache_hit) begin
                        state             <= EXP_RST;
                        ctl_reset_mod_exp <= 1'b1;
                    end else begin
                        state              <= INV_RST;
                        ctl_reset_inverter <= 1'b1;
                    end
                end
                INV_RST: begin
                    if (rst_cnt == RST_LAST) begin
                        state              <= INV_WAIT;
                        ctl_reset_inverter <= 1'b0;
                        wait_cnt           <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + 4'd1;
                    end
                end
                INV_WAIT: begin
                    if (fin_ok) begin
                        state             <= EXP_RST;
                        ctl_reset_mod_exp <= 1'b1;
                        rst_cnt           <= '0;
                    end else if (timed_out) begin
                        state  <= DONE;
                        result <= '0;
                        err    <= 1'b1;
                        done_a <= !owner_b;
                        done_b <= owner_b;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                EXP_RST: begin
                    if (rst_cnt == RST_LAST) begin
                        state             <= EXP_WAIT;
                        ctl_reset_mod_exp <= 1'b0;
                        wait_cnt          <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + 4'd1;
                    end
                end
                EXP_WAIT: begin
                    if (fin_ok || timed_out) begin
                        state  <= DONE;
                        result <= fin_ok ? ctl_msg_out : '0;
                        err    <= !fin_ok;
                        done_a <= !owner_b;
                        done_b <= owner_b;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rsa_job_scheduler.sv
// Directed bench: behavioural control stub plus a scoreboard of expected job outcomes.
module tb_rsa_job_scheduler;
    localparam int W  = 128;
    localparam int R  = 2;
    localparam int TO = 20;
`ifdef RSA_KEY_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    localparam logic [W-1:0] P1 = 128'd113680897410347;
    localparam logic [W-1:0] Q1 = 128'd7999808077935876437321;
    localparam logic [W-1:0] PK = 128'd8475698667747010771;
    localparam logic [W-1:0] QK = 128'd11297384090418420749;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic req_a = 1'b0, req_b = 1'b0, ed_a = 1'b0, ed_b = 1'b0;
    logic [W-1:0] p_a = '0, q_a = '0, p_b = '0, q_b = '0;
    logic [2*W-1:0] msg_a = '0, msg_b = '0;
    logic gnt_a, gnt_b, done_a, done_b, err, busy;
    logic [2*W-1:0] result, ctl_msg_in, ctl_msg_out;
    logic [W-1:0] ctl_p, ctl_q;
    logic ctl_encrypt_decrypt, ctl_reset_inverter, ctl_reset_mod_exp;
    logic ctl_inverter_finish, ctl_mod_exp_finish;

    rsa_job_scheduler #(.WIDTH(W), .RST_CYCLES(R), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_a(req_a), .p_a(p_a), .q_a(q_a), .ed_a(ed_a), .msg_a(msg_a),
        .gnt_a(gnt_a), .done_a(done_a),
        .req_b(req_b), .p_b(p_b), .q_b(q_b), .ed_b(ed_b), .msg_b(msg_b),
        .gnt_b(gnt_b), .done_b(done_b),
        .result(result), .err(err), .busy(busy),
        .ctl_p(ctl_p), .ctl_q(ctl_q), .ctl_encrypt_decrypt(ctl_encrypt_decrypt),
        .ctl_msg_in(ctl_msg_in), .ctl_reset_inverter(ctl_reset_inverter),
        .ctl_reset_mod_exp(ctl_reset_mod_exp), .ctl_inverter_finish(ctl_inverter_finish),
        .ctl_mod_exp_finish(ctl_mod_exp_finish), .ctl_msg_out(ctl_msg_out)
    );

    always #5 clk = ~clk;

    // Stand-in cipher for the control core: reversible so a decrypt job undoes an encrypt job.
    function automatic logic [2*W-1:0] cipher(input logic [W-1:0] p, input logic [W-1:0] q,
                                              input logic ed, input logic [2*W-1:0] m);
        return ed ? (m - {q, p}) : (m + {q, p});
    endfunction

    logic [7:0] inv_since = 8'hff, exp_since = 8'hff, inv_lat = 8'd0, exp_lat = 8'd0;
    logic inv_armed = 1'b0, exp_armed = 1'b0, stale = 1'b0, never_inv = 1'b0;

    always @(posedge clk) begin
        if (ctl_reset_inverter) begin
            inv_since <= 8'd0;
            inv_armed <= 1'b1;
        end else if (inv_since != 8'hff) begin
            inv_since <= inv_since + 8'd1;
        end
        if (ctl_reset_mod_exp) begin
            exp_since <= 8'd0;
            exp_armed <= 1'b1;
        end else if (exp_since != 8'hff) begin
            exp_since <= exp_since + 8'd1;
        end
    end

    assign ctl_inverter_finish = stale || (!never_inv && !ctl_reset_inverter && inv_armed && inv_since >= inv_lat);
    assign ctl_mod_exp_finish  = stale || (!ctl_reset_mod_exp && exp_armed && exp_since >= exp_lat);
    assign ctl_msg_out = ctl_mod_exp_finish ? cipher(ctl_p, ctl_q, ctl_encrypt_decrypt, ctl_msg_in)
                                            : {(2*W){1'b1}};

    int cyc = 0;
    int inv_tot = 0, exp_tot = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (ctl_reset_inverter) inv_tot <= inv_tot + 1;
        if (ctl_reset_mod_exp)  exp_tot <= exp_tot + 1;
    end

    typedef struct {
        logic           b;
        logic [W-1:0]   p;
        logic [W-1:0]   q;
        logic           ed;
        logic [2*W-1:0] msg;
        logic [2*W-1:0] res;
        logic           err;
        int             lat;
        int             inv_n;
        int             exp_n;
    } exp_t;

    exp_t sb[$];
    logic cv = 1'b0;
    logic [W-1:0] cp = '0, cq = '0;
    int total = 0, bad = 0;
    int gnt_cyc = 0, inv_mark = 0, exp_mark = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int wait_len(input logic [7:0] lat);
        return ((lat > 8'd1) ? int'(lat) : 1) + 1;
    endfunction

    task automatic push(input logic b, input logic [W-1:0] p, input logic [W-1:0] q,
                        input logic ed, input logic [2*W-1:0] msg);
        exp_t e;
        logic hit;
        int wi, we;
        hit = CACHE && cv && (p == cp) && (q == cq);
        wi = stale ? 2 : wait_len(inv_lat);
        we = stale ? 2 : wait_len(exp_lat);
        e.b = b; e.p = p; e.q = q; e.ed = ed; e.msg = msg;
        if (never_inv && !hit) begin
            e.res = '0; e.err = 1'b1; e.lat = R + TO + 1; e.inv_n = R; e.exp_n = 0;
            cv = 1'b0;
        end else begin
            e.res = cipher(p, q, ed, msg); e.err = 1'b0;
            e.lat = hit ? (R + we + 1) : (2*R + wi + we + 1);
            e.inv_n = hit ? 0 : R; e.exp_n = R;
            cv = 1'b1; cp = p; cq = q;
        end
        sb.push_back(e);
    endtask

    task automatic drive_a(input logic [W-1:0] p, input logic [W-1:0] q, input logic ed, input logic [2*W-1:0] m);
        p_a = p; q_a = q; ed_a = ed; msg_a = m; req_a = 1'b1;
    endtask

    task automatic drive_b(input logic [W-1:0] p, input logic [W-1:0] q, input logic ed, input logic [2*W-1:0] m);
        p_b = p; q_b = q; ed_b = ed; msg_b = m; req_b = 1'b1;
    endtask

    task automatic wait_gnt(input logic b, input int want_lat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(gnt_a || gnt_b) && n < 100);
        chk("gnt_seen", 256'(gnt_a || gnt_b), 256'd1);
        chk("gnt_owner", 256'({gnt_b, gnt_a}), 256'(b ? 2'b10 : 2'b01));
        if (want_lat > 0) chk("req_to_gnt", 256'(n), 256'(want_lat));
        gnt_cyc = cyc; inv_mark = inv_tot; exp_mark = exp_tot;
        if (b) req_b = 1'b0; else req_a = 1'b0;
    endtask

    task automatic wait_done();
        exp_t e;
        int n;
        e = sb.pop_front();
        @(negedge clk);
        n = 1;
        chk("gnt_one_cycle", 256'(gnt_a || gnt_b), 256'd0);
        while (!(done_a || done_b) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 256'(done_a || done_b), 256'd1);
        chk("done_owner", 256'({done_b, done_a}), 256'(e.b ? 2'b10 : 2'b01));
        chk("gnt_to_done", 256'(cyc - gnt_cyc), 256'(e.lat));
        chk("result", result, e.res);
        chk("err", 256'(err), 256'(e.err));
        chk("busy_in_done", 256'(busy), 256'd1);
        chk("inv_pulse_cycles", 256'(inv_tot - inv_mark), 256'(e.inv_n));
        chk("exp_pulse_cycles", 256'(exp_tot - exp_mark), 256'(e.exp_n));
        chk("ctl_p_held", 256'(ctl_p), 256'(e.p));
        chk("ctl_q_held", 256'(ctl_q), 256'(e.q));
        chk("ctl_ed_held", 256'(ctl_encrypt_decrypt), 256'(e.ed));
        chk("ctl_msg_held", ctl_msg_in, e.msg);
        @(negedge clk);
        chk("done_one_cycle", 256'(done_a || done_b), 256'd0);
        chk("busy_idle", 256'(busy), 256'd0);
        chk("result_hold", result, e.res);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2*W-1:0] ct;
        repeat (2) @(negedge clk);
        chk("reset_ctrl_outs", 256'({gnt_a, gnt_b, done_a, done_b, err, busy,
                                     ctl_reset_inverter, ctl_reset_mod_exp, ctl_encrypt_decrypt}), 256'd0);
        chk("reset_result", result, 256'd0);
        chk("reset_ctl_pq", 256'({ctl_p, ctl_q}), 256'd0);
        chk("reset_ctl_msg", ctl_msg_in, 256'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // single job
        inv_lat = 8'd3; exp_lat = 8'd2;
        drive_a(P1, Q1, 1'b0, 256'hb37b2800); push(1'b0, P1, Q1, 1'b0, 256'hb37b2800);
        wait_gnt(1'b0, 1); wait_done();

        // round trip: A encrypts, B decrypts A's result
        drive_a(P1, Q1, 1'b0, 256'h57e7e100); push(1'b0, P1, Q1, 1'b0, 256'h57e7e100);
        wait_gnt(1'b0, 1); wait_done();
        ct = result;
        drive_b(P1, Q1, 1'b1, ct); push(1'b1, P1, Q1, 1'b1, ct);
        wait_gnt(1'b1, 1); wait_done();
        chk("round_trip", result, 256'h57e7e100);

        // simultaneous requests from reset
        reset_n = 1'b0; cv = 1'b0;
        @(negedge clk);
        reset_n = 1'b1; inv_lat = 8'd0; exp_lat = 8'd0;
        @(negedge clk);
        drive_a(128'd11, 128'd13, 1'b0, 256'h1234); drive_b(128'd17, 128'd19, 1'b1, 256'h5678);
        push(1'b0, 128'd11, 128'd13, 1'b0, 256'h1234); push(1'b1, 128'd17, 128'd19, 1'b1, 256'h5678);
        wait_gnt(1'b0, 1); wait_done(); wait_gnt(1'b1, 1); wait_done();
        drive_a(128'd23, 128'd29, 1'b1, 256'h9abc); drive_b(128'd31, 128'd37, 1'b0, 256'hdef0);
        push(1'b0, 128'd23, 128'd29, 1'b1, 256'h9abc); push(1'b1, 128'd31, 128'd37, 1'b0, 256'hdef0);
        wait_gnt(1'b0, 1); wait_done(); wait_gnt(1'b1, 1); wait_done();
        drive_a(128'd41, 128'd43, 1'b0, 256'h1111); push(1'b0, 128'd41, 128'd43, 1'b0, 256'h1111);
        wait_gnt(1'b0, 1); wait_done();
        drive_a(128'd47, 128'd53, 1'b0, 256'h2222); drive_b(128'd59, 128'd61, 1'b1, 256'h3333);
        push(1'b1, 128'd59, 128'd61, 1'b1, 256'h3333); push(1'b0, 128'd47, 128'd53, 1'b0, 256'h2222);
        wait_gnt(1'b1, 1); wait_done(); wait_gnt(1'b0, 1); wait_done();

        // finish held high across the reset pulse
        stale = 1'b1; inv_lat = 8'd4; exp_lat = 8'd4;
        drive_a(128'd67, 128'd71, 1'b0, 256'h4444); push(1'b0, 128'd67, 128'd71, 1'b0, 256'h4444);
        wait_gnt(1'b0, 1); wait_done();
        stale = 1'b0; inv_lat = 8'd1; exp_lat = 8'd1;

        // inverter never finishes
        never_inv = 1'b1;
        drive_a(128'd73, 128'd79, 1'b0, 256'h5555); push(1'b0, 128'd73, 128'd79, 1'b0, 256'h5555);
        wait_gnt(1'b0, 1); wait_done();
        never_inv = 1'b0;
        drive_a(128'd73, 128'd79, 1'b0, 256'h6666); push(1'b0, 128'd73, 128'd79, 1'b0, 256'h6666);
        wait_gnt(1'b0, 1); wait_done();

        // back-to-back jobs with the same key
        drive_a(PK, QK, 1'b0, 256'h7777); push(1'b0, PK, QK, 1'b0, 256'h7777);
        wait_gnt(1'b0, 1); wait_done();
        drive_b(PK, QK, 1'b0, 256'h8888); push(1'b1, PK, QK, 1'b0, 256'h8888);
        wait_gnt(1'b1, 1); wait_done();

        // reset mid-job
        drive_a(PK, QK, 1'b1, 256'h9999);
        wait_gnt(1'b0, 1);
        @(negedge clk);
        chk("pulse_before_abort", 256'(ctl_reset_inverter || ctl_reset_mod_exp), 256'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_rst_pulses_drop", 256'({ctl_reset_inverter, ctl_reset_mod_exp}), 256'd0);
        chk("abort_busy", 256'(busy), 256'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done_gnt", 256'({done_a, done_b, gnt_a, gnt_b}), 256'd0);
        end
        cv = 1'b0; reset_n = 1'b1;
        @(negedge clk);
        chk("abort_idle", 256'({busy, done_a, done_b}), 256'd0);
        drive_a(PK, QK, 1'b0, 256'haaaa); push(1'b0, PK, QK, 1'b0, 256'haaaa);
        wait_gnt(1'b0, 1); wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
